dt_tree_walker: RTL and testbench

Parametrised decision-tree inference engine: holds a complete binary tree of split nodes in a register table and walks it one level per clock for each accepted feature vector. Each level performs the unsigned compare `feature <= threshold`, taking the left child on true and the right child on false. Sits between the feature-capture stage and the class-vote/output stage of the DT classifier. Unlike the single-node comparator, it:
- selects the feature per node;
- supports early leaves, giving unbalanced trees;
- is runtime-loadable;
- uses valid/ready handshakes on both sides.

---
 rtl/dt_pkg.sv | 15 +
 rtl/dt_split_cmp.sv | 25 ++
 rtl/dt_tree_walker.sv | 99 +++++++++
 tb/tb_dt_tree_walker.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// dt_pkg: shared FSM state encoding and width helpers for the decision-tree walker.
package dt_pkg;

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    function automatic int fsel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Heap-indexed complete tree with levels 0..d holds 2^(d+1)-1 nodes.
    function automatic int node_count(input int d);
        return (1 << (d + 1)) - 1;
    endfunction

endpackage

// File: rtl/dt_split_cmp.sv
// dt_split_cmp: picks the node's feature (out-of-range selects fall back to feature 0) and flags a right turn.
module dt_split_cmp
    import dt_pkg::*;
#(
    parameter int FEATURE_WIDE = 7,
    parameter int N_FEATURES   = 4
) (
    input  logic [N_FEATURES*FEATURE_WIDE-1:0] i_features,
    input  logic [fsel_w(N_FEATURES)-1:0]      i_feat_sel,
    input  logic [FEATURE_WIDE-1:0]            i_threshold,
    output logic                               o_go_right
);

    logic [FEATURE_WIDE-1:0] w_sel;

    always_comb begin
        w_sel = i_features[FEATURE_WIDE-1:0];
        for (int k = 1; k < N_FEATURES; k++)
            if (int'(i_feat_sel) == k) w_sel = i_features[k*FEATURE_WIDE +: FEATURE_WIDE];
    end

    // Equality goes left.
    assign o_go_right = w_sel > i_threshold;

endmodule

// File: rtl/dt_tree_walker.sv
// dt_tree_walker: runtime-loadable decision tree, walked one level per clock per accepted feature vector.
module dt_tree_walker
    import dt_pkg::*;
#(
    parameter int FEATURE_WIDE = 7,
    parameter int N_FEATURES   = 4,
    parameter int DEPTH        = 3,
    parameter int CLASS_WIDE   = 2
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              cfg_we,
    input  logic [DEPTH:0]                                    cfg_addr,
    input  logic [CLASS_WIDE+fsel_w(N_FEATURES)+FEATURE_WIDE:0] cfg_data,
    output logic                                              cfg_busy,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [N_FEATURES*FEATURE_WIDE-1:0]                features,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [CLASS_WIDE-1:0]                             out_class,
    output logic [$clog2(DEPTH+1)-1:0]                        out_depth
);

    localparam int FSEL_W = fsel_w(N_FEATURES);
    localparam int NODES  = node_count(DEPTH);
    localparam int LW     = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                    is_leaf;
        logic [CLASS_WIDE-1:0]   cls;
        logic [FSEL_W-1:0]       feat_sel;
        logic [FEATURE_WIDE-1:0] threshold;
    } node_t;

    state_t                            r_state, w_next;
    node_t                             r_nodes [1:NODES];
    node_t                             w_node;
    logic [N_FEATURES*FEATURE_WIDE-1:0] r_feat;
    logic [DEPTH:0]                    r_cur;
    logic [LW-1:0]                     r_level, r_depth;
    logic [CLASS_WIDE-1:0]             r_class;
    logic                              w_leaf, w_go_right, w_accept;

    assign w_node    = r_nodes[r_cur];
    assign w_leaf    = w_node.is_leaf || (r_level == LW'(DEPTH));
    assign w_accept  = in_valid && in_ready;
    assign out_class = r_class;
    assign out_depth = r_depth;

    dt_split_cmp #(.FEATURE_WIDE(FEATURE_WIDE), .N_FEATURES(N_FEATURES)) u_cmp (
        .i_features (r_feat),
        .i_feat_sel (w_node.feat_sel),
        .i_threshold(w_node.threshold),
        .o_go_right (w_go_right)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next    = r_state;
        in_ready  = r_state == IDLE;
        out_valid = r_state == DONE;
        cfg_busy  = r_state != IDLE;
        if (r_state == IDLE && in_valid)  w_next = WALK;
        if (r_state == WALK && w_leaf)    w_next = DONE;
        if (r_state == DONE && out_ready) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= NODES; i++) r_nodes[i] <= '0;
            r_feat  <= '0;
            r_cur   <= '0;
            r_level <= '0;
            r_depth <= '0;
            r_class <= '0;
        end else begin
            // Writes land only while idle, so a walk never sees its table change underneath it.
            if (cfg_we && r_state == IDLE && cfg_addr != '0) r_nodes[cfg_addr] <= node_t'(cfg_data);
            if (w_accept) begin
                r_feat  <= features;
                r_cur   <= (DEPTH+1)'(1);
                r_level <= '0;
            end else if (r_state == WALK) begin
                if (w_leaf) begin
                    r_class <= w_node.cls;
                    r_depth <= r_level;
                end else begin
                    r_cur   <= {r_cur[DEPTH-1:0], w_go_right};
                    r_level <= r_level + LW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dt_tree_walker.sv
// tb_dt_tree_walker: directed scenarios with a result scoreboard for dt_tree_walker.
module tb_dt_tree_walker;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        cfg_we = 0;
    logic [3:0]  cfg_addr = '0;
    logic [11:0] cfg_data = '0;
    logic        cfg_busy;
    logic        in_valid = 0;
    logic        in_ready;
    logic [27:0] features = '0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [1:0]  out_class;
    logic [1:0]  out_depth;

    typedef struct {
        logic [1:0] cls;
        int         dep;
        int         lat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    dt_tree_walker #(.FEATURE_WIDE(7), .N_FEATURES(4), .DEPTH(3), .CLASS_WIDE(2)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_busy(cfg_busy), .in_valid(in_valid), .in_ready(in_ready), .features(features),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_depth(out_depth)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] nd(input bit leaf, input int cls, input int fsel, input int thr);
        return {leaf, 2'(cls), 2'(fsel), 7'(thr)};
    endfunction

    function automatic logic [27:0] fv(input int f0, input int f2);
        return {7'd0, 7'(f2), 7'd0, 7'(f0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input int addr, input logic [11:0] d);
        @(negedge clk);
        cfg_we = 1; cfg_addr = 4'(addr); cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 0;
    endtask

    task automatic run(input logic [27:0] f, input int ecls, input int edep, input int elat,
                       input int hold, input bit wr_walk, input bit wr_acc, input logic [11:0] acc_d);
        exp_t e;
        int   n;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        features = f; in_valid = 1;
        if (wr_acc) begin cfg_we = 1; cfg_addr = 4'd1; cfg_data = acc_d; end
        q.push_back('{2'(ecls), edep, elat});
        @(posedge clk); #1;
        in_valid = 0; cfg_we = 0; features = 28'($urandom);
        chk("busy_walk", cfg_busy, 1);
        if (wr_walk) begin cfg_we = 1; cfg_addr = 4'd2; cfg_data = nd(1, 3, 0, 0); end
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            cfg_we = 0;
            n++;
        end
        cfg_we = 0;
        e = q.pop_front();
        chk("out_valid", out_valid, 1);
        chk("latency", n, e.lat);
        chk("out_class", out_class, e.cls);
        chk("out_depth", out_depth, e.dep);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom); features = 28'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_class", out_class, e.cls);
            chk("hold_depth", out_depth, e.dep);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("ready_after_handoff", in_ready, 1);
        chk("valid_after_handoff", out_valid, 0);
        chk("busy_after_handoff", cfg_busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_class", out_class, 0);
        chk("rst_out_depth", out_depth, 0);
        chk("rst_busy", cfg_busy, 0);

        // Cleared table: everything goes left to forced leaf node8.
        run(fv(0, 0), 0, 3, 4, 0, 0, 0, '0);

        cfg_write(1, nd(0, 0, 0, 50));
        cfg_write(2, nd(1, 1, 0, 0));
        cfg_write(3, nd(0, 0, 2, 20));
        cfg_write(6, nd(1, 2, 0, 0));
        cfg_write(7, nd(1, 3, 0, 0));
        run(fv(60, 20), 2, 2, 3, 0, 0, 0, '0);
        run(fv(60, 21), 3, 2, 3, 0, 0, 0, '0);
        run(fv(50, 99), 1, 1, 2, 0, 0, 0, '0);

        // Backpressure with toggling inputs.
        run(fv(60, 21), 3, 2, 3, 5, 0, 0, '0);

        // Write during WALK is dropped.
        run(fv(10, 0), 1, 1, 2, 0, 1, 0, '0);
        run(fv(10, 0), 1, 1, 2, 0, 0, 0, '0);

        // Write to address 0 is dropped.
        cfg_write(0, nd(1, 3, 0, 0));
        run(fv(50, 0), 1, 1, 2, 0, 0, 0, '0);

        // Write in the accept cycle turns the root into a class-3 leaf for this very walk.
        run(fv(60, 21), 3, 0, 1, 0, 0, 1, nd(1, 3, 0, 0));
        run(fv(0, 0), 3, 0, 1, 0, 0, 0, '0);

        // Reset mid-walk.
        cfg_write(1, nd(0, 0, 0, 50));
        @(negedge clk);
        features = fv(60, 21); in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_class", out_class, 0);
        chk("midrst_out_depth", out_depth, 0);
        chk("midrst_busy", cfg_busy, 0);
        @(negedge clk);
        rst_n = 1;
        // Cleared table: thresholds 0, f0=60 goes right each level to forced leaf node15.
        run(fv(60, 21), 0, 3, 4, 0, 0, 0, '0);
        run(fv(0, 0), 0, 3, 4, 0, 0, 0, '0);

        chk("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
